alu_slice_mux8: RTL and testbench
=================================

// Module: alu_slice_mux8
// PURPOSE
// - Registered WIDTH-bit ALU built from a ripple chain of per-bit slices.
// - Each slice is a full adder feeding an 8:1 function multiplexer.
// - Sits in the datapath between operand registers and the result/flag bus.
// - Latency is one cycle, qualified by a valid strobe.
// PARAMETERS
// - WIDTH  default 8  operand/result width in bits (>=2)
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      operands/sel valid this cycle
// - sel        in   3      function select {s2,s1,s0}
// - a          in   WIDTH  operand A
// - b          in   WIDTH  operand B
// - out_valid  out  1      result/flags valid (in_valid delayed 1 cycle)
// - result     out  WIDTH  registered function result
// - carry      out  1      registered carry-out of the adder chain (ADD/SUB only)
// - zero       out  1      registered: result == 0
// - overflow   out  1      registered signed overflow (ADD/SUB only)
// BEHAVIOUR
// - Reset: while rst_n=0, out_valid, result, carry, zero and overflow are all 0.
//   Reset takes effect immediately and asynchronously, including mid-operation.
// - Function select, with mux input i chosen when sel==i:
//   - 000 ADD   a + b, cin=0
//   - 001 SUB   a + ~b, cin=1
//   - 010 XOR   a ^ b
//   - 011 XOR   alias of 010
//   - 100 AND   a & b
//   - 101 NAND  ~(a & b)
//   - 110 NOR   ~(a | b)
//   - 111 OR    a | b
// - Slice i: binv = b[i] ^ (sel==001); the full adder computes a[i]+binv+c[i].
//   - c[0] = (sel==001); c[i+1] = carry of slice i.
// - carry is c[WIDTH] for ADD/SUB and 0 otherwise.
//   - For SUB, carry=1 means no borrow (a >= b unsigned).
// - overflow = c[WIDTH] ^ c[WIDTH-1] for ADD/SUB, 0 otherwise.
// - zero is computed from the same result being registered, not the previous one.
// - Registers update on a clk edge only when in_valid=1.
//   - When in_valid=0, result and flags hold their values and out_valid drops to 0.
// - Arithmetic wraps modulo 2^WIDTH. No saturation.
// STRUCTURE
// - Shared package alu_pkg: 3-bit opcode localparams
//   OP_ADD, OP_SUB, OP_XOR, OP_XOR2, OP_AND, OP_NAND, OP_NOR, OP_OR.
// - Sub-module alu_bit_slice is purely combinational: full adder plus 8:1 mux.
//   - Inputs: a, b, cin, sel[2:0].
//   - Outputs: out, cout.
//   - Instantiated WIDTH times via generate.
// - Top level contains the carry chain, flag logic and output registers.
// TESTING (WIDTH=8; check outputs one cycle after in_valid)
// - ADD a=FF b=01 -> result=00 carry=1 zero=1 overflow=0
// - ADD a=7F b=01 -> result=80 carry=0 zero=0 overflow=1
// - SUB a=05 b=05 -> result=00 carry=1 zero=1; SUB a=80 b=01 -> 7F carry=1 overflow=1
// - a=F0 b=CC across sel=010/011/100/101/110/111 -> 3C/3C/C0/3F/03/FC, carry=0 overflow=0
// - in_valid=0 for 3 cycles after a valid op -> result and flags held, out_valid=0
// - rst_n low between clk edges during an in-flight op -> all outputs 0 immediately;
//   first valid op after release produces the correct result

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and helpers for the sliced ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XOR2 = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  // Carry and overflow flags are only meaningful for the adder functions.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One bit of the ALU: full adder with optional B inversion feeding an 8:1 function mux.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] sel,
  output logic       out,
  output logic       cout
);

  logic binv;
  logic sum;

  always_comb begin
    binv = b ^ (sel == OP_SUB);
    sum  = a ^ binv ^ cin;
    cout = (a & binv) | (a & cin) | (binv & cin);
  end

  always_comb begin
    out = 1'b0;
    unique case (sel)
      OP_ADD:  out = sum;
      OP_SUB:  out = sum;
      OP_XOR:  out = a ^ b;
      OP_XOR2: out = a ^ b;
      OP_AND:  out = a & b;
      OP_NAND: out = ~(a & b);
      OP_NOR:  out = ~(a | b);
      OP_OR:   out = a | b;
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_slice_mux8.sv
// Registered WIDTH-bit ALU: ripple chain of bit slices, flag logic and output registers.
module alu_slice_mux8
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             zero_d;
  logic             overflow_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             overflow_q;

  // SUB is a + ~b + 1, so the chain's carry-in doubles as the "+1".
  assign c[0] = (sel == OP_SUB);

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    alu_bit_slice u_slice (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sel  (sel),
      .out  (result_d[i]),
      .cout (c[i+1])
    );
  end

  always_comb begin
    carry_d    = is_arith(sel) & c[WIDTH];
    overflow_d = is_arith(sel) & (c[WIDTH] ^ c[WIDTH-1]);
    zero_d     = ~|result_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q   <= result_d;
        carry_q    <= carry_d;
        zero_q     <= zero_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_slice_mux8.sv
// Self-checking bench for alu_slice_mux8 against an arithmetic reference model.
module tb_alu_slice_mux8;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [2:0]   sel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         overflow;

  int n_cmp;
  int n_err;

  // Model state: last registered {result, carry, zero, overflow}.
  logic [W+2:0] held;

  alu_slice_mux8 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {result, carry, zero, overflow} from plain arithmetic.
  function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    int          ux, uy, s;
    logic [W-1:0] r;
    logic        cy, ov;
    ux = int'(x);
    uy = int'(y);
    cy = 1'b0;
    ov = 1'b0;
    case (op)
      OP_ADD: begin
        s  = ux + uy;
        r  = s[W-1:0];
        cy = (s >= (1 << W));
        ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      OP_SUB: begin
        s  = ux - uy + (1 << W);
        r  = s[W-1:0];
        cy = (ux >= uy);
        ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      OP_XOR, OP_XOR2: r = x ^ y;
      OP_AND:          r = x & y;
      OP_NAND:         r = ~(x & y);
      OP_NOR:          r = ~(x | y);
      default:         r = x | y;
    endcase
    return {r, cy, (r == '0), ov};
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    @(negedge clk);
    in_valid = v;
    sel      = op;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    if (v) held = model(op, x, y);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = '0;
    a        = '0;
    b        = '0;
    held     = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, result, carry, zero, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset: got %h want 0", {out_valid, result, carry, zero, overflow});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]   ops [10] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_XOR, OP_XOR2,
                               OP_AND, OP_NAND, OP_NOR, OP_OR};
    logic [W-1:0] xs  [10] = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'hF0, 8'hF0,
                               8'hF0, 8'hF0, 8'hF0, 8'hF0};
    logic [W-1:0] ys  [10] = '{8'h01, 8'h01, 8'h05, 8'h01, 8'hCC, 8'hCC,
                               8'hCC, 8'hCC, 8'hCC, 8'hCC};
    // Hand-derived {valid, result, carry, zero, overflow}.
    logic [W+3:0] want [10] = '{{1'b1, 8'h00, 3'b110}, {1'b1, 8'h80, 3'b001},
                                {1'b1, 8'h00, 3'b110}, {1'b1, 8'h7F, 3'b101},
                                {1'b1, 8'h3C, 3'b000}, {1'b1, 8'h3C, 3'b000},
                                {1'b1, 8'hC0, 3'b000}, {1'b1, 8'h3F, 3'b000},
                                {1'b1, 8'h03, 3'b000}, {1'b1, 8'hFC, 3'b000}};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ops[i], xs[i], ys[i]);
      n_cmp++;
      if ({out_valid, result, carry, zero, overflow} !== want[i]) begin
        n_err++;
        $display("FAIL directed[%0d] sel=%b a=%h b=%h: got %h want %h", i, ops[i], xs[i],
                 ys[i], {out_valid, result, carry, zero, overflow}, want[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, OP_ADD, 8'h12, 8'h34);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, $urandom_range(0, 7), W'($urandom), W'($urandom));
      n_cmp++;
      if ({out_valid, result, carry, zero, overflow} !== {1'b0, 8'h46, 3'b000}) begin
        n_err++;
        $display("FAIL hold[%0d]: got %h want %h", i, {out_valid, result, carry, zero, overflow},
                 {1'b0, 8'h46, 3'b000});
      end
    end
  endtask

  task automatic test_random();
    logic v;
    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 3) != 0);
      drive(v, $urandom_range(0, 7), W'($urandom), W'($urandom));
      n_cmp++;
      if ({out_valid, result, carry, zero, overflow} !== {v, held}) begin
        n_err++;
        $display("FAIL random[%0d] v=%b sel=%b a=%h b=%h: got %h want %h", i, v, sel, a, b,
                 {out_valid, result, carry, zero, overflow}, {v, held});
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, OP_SUB, 8'h80, 8'h01);
    n_cmp++;
    if ({out_valid, result, carry, zero, overflow} !== {1'b1, 8'h7F, 3'b101}) begin
      n_err++;
      $display("FAIL pre_reset: got %h want %h", {out_valid, result, carry, zero, overflow},
               {1'b1, 8'h7F, 3'b101});
    end
    // Next op is in flight; pull reset before its capturing edge.
    in_valid = 1'b1;
    sel      = OP_OR;
    a        = 8'h5A;
    b        = 8'h0F;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, result, carry, zero, overflow} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got %h want 0", {out_valid, result, carry, zero, overflow});
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    drive(1'b1, OP_ADD, 8'hC8, 8'h64);
    n_cmp++;
    if ({out_valid, result, carry, zero, overflow} !== {1'b1, 8'h2C, 3'b100}) begin
      n_err++;
      $display("FAIL post_reset: got %h want %h", {out_valid, result, carry, zero, overflow},
               {1'b1, 8'h2C, 3'b100});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
